// File: rtl/ext_mem_hub_pkg.sv
// ext_mem_hub_pkg: shared state/grant encodings and default widths for the external memory hub.
package ext_mem_hub_pkg;
  typedef enum logic [2:0] {IDLE, WR_CMD, WR_DATA, RD_CMD, RD_DATA} state_t;
  typedef enum logic {GNT_RD = 1'b0, GNT_WR = 1'b1} grant_t;
  localparam int EXT_BUF_MEM_ADDR_WIDTH = 32;
  localparam int EXT_BUF_MEM_DATA_WIDTH = 32;
  localparam int LEN_W = 8;
endpackage

// File: rtl/ext_mem_hub_arb.sv
// ext_mem_hub_arb: write/read tie-break; round-robin by default, read-priority with write-starvation
// guard when EXT_MEM_HUB_RD_PRIORITY_EN is defined.
module ext_mem_hub_arb
  import ext_mem_hub_pkg::*;
`ifdef EXT_MEM_HUB_RD_PRIORITY_EN
#(
  parameter int RD_STREAK_MAX = 4
)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic wreq,
  input  logic rreq,
  input  logic take,
  output logic gnt_wr
);
`ifdef EXT_MEM_HUB_RD_PRIORITY_EN
  localparam int SW = $clog2(RD_STREAK_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(RD_STREAK_MAX);
  logic [SW-1:0] streak_q, streak_d;
  always_comb begin
    gnt_wr = wreq & (!rreq | streak_q == SMAX);
    streak_d = !take ? streak_q : gnt_wr ? '0 : wreq ? streak_q + 1'b1 : streak_q;
  end
  always_ff @(posedge clk)
    if (rst) streak_q <= '0;
    else     streak_q <= streak_d;
`else
  grant_t last_grant_q, last_grant_d;
  always_comb begin
    gnt_wr = wreq & (!rreq | last_grant_q == GNT_RD);
    last_grant_d = !take ? last_grant_q : gnt_wr ? GNT_WR : GNT_RD;
  end
  always_ff @(posedge clk)
    if (rst) last_grant_q <= GNT_RD;
    else     last_grant_q <= last_grant_d;
`endif
endmodule

// File: rtl/ext_mem_hub.sv
// ext_mem_hub: arbitrates the external frame-buffer port between burst writer and burst reader.
// Define EXT_MEM_HUB_RD_PRIORITY_EN for read-priority ties instead of round-robin.
module ext_mem_hub
  import ext_mem_hub_pkg::*;
#(
  parameter int ADDR_W = EXT_BUF_MEM_ADDR_WIDTH,
  parameter int DATA_W = EXT_BUF_MEM_DATA_WIDTH
`ifdef EXT_MEM_HUB_RD_PRIORITY_EN
  , parameter int RD_STREAK_MAX = 4
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_burst,
  input  logic [LEN_W-1:0]  wr_burst_len_minus1,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [LEN_W-1:0]  rd_len_minus1,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_valid,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic              mem_cmd_write,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  output logic [LEN_W-1:0]  mem_cmd_len_minus1,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wvalid,
  input  logic              mem_wready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              proto_err
);
  state_t state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic cmd_valid_q, cmd_valid_d, cmd_write_q, cmd_write_d;
  logic rd_ack_q, rd_ack_d, proto_err_q, proto_err_d;
  logic wreq, take, gnt_wr;
  assign wreq = wr_burst & wr_valid;
  assign take = (state_q == IDLE) & (wreq | rd_req);
  ext_mem_hub_arb
`ifdef EXT_MEM_HUB_RD_PRIORITY_EN
    #(.RD_STREAK_MAX(RD_STREAK_MAX))
`endif
  u_arb (.clk(clk), .rst(rst), .wreq(wreq), .rreq(rd_req), .take(take), .gnt_wr(gnt_wr));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    len_d = len_q;
    addr_d = addr_q;
    cmd_valid_d = cmd_valid_q;
    cmd_write_d = cmd_write_q;
    rd_ack_d = 1'b0;
    proto_err_d = proto_err_q | (mem_rvalid & state_q != RD_DATA);
    case (state_q)
      IDLE: if (take) begin
        state_d = gnt_wr ? WR_CMD : RD_CMD;
        cmd_valid_d = 1'b1;
        cmd_write_d = gnt_wr;
        addr_d = gnt_wr ? wr_addr : rd_addr;
        len_d = gnt_wr ? wr_burst_len_minus1 : rd_len_minus1;
      end
      WR_CMD, RD_CMD: if (mem_cmd_ready) begin
        state_d = state_q == WR_CMD ? WR_DATA : RD_DATA;
        cmd_valid_d = 1'b0;
        cnt_d = '0;
        rd_ack_d = state_q == RD_CMD;
      end
      // Compare before increment so len 255 ends on the 256th beat without wrapping.
      WR_DATA, RD_DATA: if (state_q == WR_DATA ? wr_valid & mem_wready : mem_rvalid) begin
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == len_q ? IDLE : state_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      len_q <= '0;
      addr_q <= '0;
      cmd_valid_q <= 1'b0;
      cmd_write_q <= 1'b0;
      rd_ack_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      addr_q <= addr_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_write_q <= cmd_write_d;
      rd_ack_q <= rd_ack_d;
      proto_err_q <= proto_err_d;
    end
  assign wr_ready = (state_q == WR_DATA) & mem_wready;
  assign mem_wvalid = (state_q == WR_DATA) & wr_valid;
  assign mem_wdata = wr_data;
  assign rd_data = mem_rdata;
  assign rd_data_valid = (state_q == RD_DATA) & mem_rvalid;
  assign rd_ack = rd_ack_q;
  assign proto_err = proto_err_q;
  assign mem_cmd_valid = cmd_valid_q;
  assign mem_cmd_write = cmd_write_q;
  assign mem_cmd_addr = addr_q;
  assign mem_cmd_len_minus1 = len_q;
endmodule

// File: tb/tb_ext_mem_hub.sv
// tb_ext_mem_hub: directed self-checking bench for ext_mem_hub (either EXT_MEM_HUB_RD_PRIORITY_EN build).
module tb_ext_mem_hub;
  localparam int AW = 16;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_burst = 0, wr_valid = 0, rd_req = 0, mem_cmd_ready = 0, mem_wready = 0, mem_rvalid = 0;
  logic [7:0] wr_burst_len_minus1 = 0, rd_len_minus1 = 0;
  logic [AW-1:0] wr_addr = 0, rd_addr = 0;
  logic [DW-1:0] wr_data = 0, mem_rdata = 0;
  logic wr_ready, rd_ack, rd_data_valid, mem_cmd_valid, mem_cmd_write, mem_wvalid, proto_err;
  logic [DW-1:0] rd_data, mem_wdata;
  logic [AW-1:0] mem_cmd_addr;
  logic [7:0] mem_cmd_len_minus1;
  int checks = 0, errors = 0, acks = 0;
  ext_mem_hub #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .wr_burst(wr_burst), .wr_burst_len_minus1(wr_burst_len_minus1),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len_minus1(rd_len_minus1), .rd_ack(rd_ack),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .mem_cmd_valid(mem_cmd_valid),
    .mem_cmd_ready(mem_cmd_ready), .mem_cmd_write(mem_cmd_write), .mem_cmd_addr(mem_cmd_addr),
    .mem_cmd_len_minus1(mem_cmd_len_minus1), .mem_wdata(mem_wdata), .mem_wvalid(mem_wvalid),
    .mem_wready(mem_wready), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .proto_err(proto_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (rd_ack) acks++;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_cmd();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_cmd_valid === 1'b1) break;
    end
    chk("wait_cmd", mem_cmd_valid, 1);
  endtask
  initial begin
    logic [5:0] exp_seq;
    int exp_beats, nvalid;
    mem_wready = 1;
    repeat (2) @(negedge clk);
    chk("reset_state", {mem_cmd_valid, rd_ack, proto_err, wr_ready, mem_wvalid, rd_data_valid}, 0);
    rst = 0;
    // lone write, len 3
    wr_burst = 1; wr_valid = 1; wr_burst_len_minus1 = 3; wr_addr = 16'h0100; wr_data = 32'hA0;
    @(negedge clk);
    chk("t1_cmd", {mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_len_minus1}, {1'b1, 1'b1, 16'h0100, 8'd3});
    chk("t1_hold", wr_ready, 0);
    mem_cmd_ready = 1;
    @(negedge clk);
    mem_cmd_ready = 0;
    chk("t1_cmd_clr", mem_cmd_valid, 0);
    for (int i = 0; i < 4; i++) begin
      wr_data = 32'hA0 + i;
      #1 chk("t1_beat", {wr_ready, mem_wvalid, mem_wdata}, {1'b1, 1'b1, 32'hA0 + 32'(i)});
      @(negedge clk);
      wr_burst = 0;
    end
    #1 chk("t1_idle", {wr_ready, mem_wvalid, mem_cmd_valid}, 0);
    wr_valid = 0;
    // lone read, len 7, data after 5 idle cycles
    rd_req = 1; rd_addr = 16'h0200; rd_len_minus1 = 7;
    @(negedge clk);
    chk("t2_cmd", {mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_len_minus1}, {1'b1, 1'b0, 16'h0200, 8'd7});
    chk("t2_noack", rd_ack, 0);
    mem_cmd_ready = 1;
    @(negedge clk);
    chk("t2_ack", {rd_ack, mem_cmd_valid}, 2'b10);
    rd_req = 0; mem_cmd_ready = 0;
    repeat (5) begin
      @(negedge clk);
      chk("t2_wait", {rd_ack, rd_data_valid}, 0);
    end
    for (int i = 0; i < 8; i++) begin
      mem_rvalid = 1; mem_rdata = 32'hC0 + i;
      #1 chk("t2_beat", {rd_data_valid, rd_data}, {1'b1, 32'hC0 + 32'(i)});
      @(negedge clk);
    end
    mem_rvalid = 0;
    chk("t2_acks", acks, 1);
    chk("t2_end", {proto_err, mem_cmd_valid}, 0);
    // simultaneous requests from reset
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    wr_burst = 1; wr_valid = 1; wr_burst_len_minus1 = 0; wr_addr = 16'h0040;
    rd_req = 1; rd_len_minus1 = 0; rd_addr = 16'h0080;
`ifdef EXT_MEM_HUB_RD_PRIORITY_EN
    exp_seq = 6'b010000;
`else
    exp_seq = 6'b010101;
`endif
    for (int g = 0; g < 6; g++) begin
      wait_cmd();
      chk("t3_grant", {mem_cmd_write, mem_cmd_addr}, {exp_seq[g], exp_seq[g] ? 16'h0040 : 16'h0080});
      mem_cmd_ready = 1;
      @(negedge clk);
      mem_cmd_ready = 0;
      mem_rvalid = !exp_seq[g];
      @(negedge clk);
      mem_rvalid = 0;
    end
    wr_burst = 0; wr_valid = 0; rd_req = 0;
    chk("t3_end", proto_err, 0);
    // command stall and toggling write-ready
    wr_burst = 1; wr_valid = 1; wr_burst_len_minus1 = 5; wr_addr = 16'h03C0; mem_wready = 0;
    wait_cmd();
    wr_addr = 16'hFFFF; wr_burst_len_minus1 = 8'hAA;
    for (int i = 0; i < 10; i++) begin
      chk("t5_stable", {mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_len_minus1}, {1'b1, 1'b1, 16'h03C0, 8'd5});
      @(negedge clk);
    end
    mem_cmd_ready = 1;
    @(negedge clk);
    mem_cmd_ready = 0; wr_burst = 0;
    exp_beats = 0;
    for (int k = 0; k < 16; k++) begin
      mem_wready = k[0];
      #1 chk("t5_wready", wr_ready, exp_beats < 6 ? mem_wready : 1'b0);
      if (exp_beats < 6 && mem_wready) exp_beats++;
      @(negedge clk);
    end
    wr_valid = 0; mem_wready = 1;
    // 256-beat read, then a stray beat
    rd_req = 1; rd_addr = 16'h1000; rd_len_minus1 = 8'd255;
    wait_cmd();
    chk("t7_cmd", {mem_cmd_write, mem_cmd_len_minus1}, {1'b0, 8'd255});
    mem_cmd_ready = 1;
    @(negedge clk);
    mem_cmd_ready = 0; rd_req = 0;
    nvalid = 0;
    for (int n = 0; n < 256; n++) begin
      mem_rvalid = 1; mem_rdata = 32'(n);
      #1 nvalid += int'(rd_data_valid);
      @(negedge clk);
    end
    chk("t7_beats", nvalid, 256);
    #1 chk("t7_over", {rd_data_valid, proto_err}, 0);
    @(negedge clk);
    mem_rvalid = 0;
    chk("t7_proto", proto_err, 1);
    // reset in the middle of a 16-beat write
    wr_burst = 1; wr_valid = 1; wr_burst_len_minus1 = 15; wr_addr = 16'h0500;
    wait_cmd();
    mem_cmd_ready = 1;
    @(negedge clk);
    mem_cmd_ready = 0; wr_burst = 0;
    repeat (2) @(negedge clk);
    #1 chk("t6_beat2", wr_ready, 1);
    rst = 1;
    @(negedge clk);
    chk("t6_rst", {wr_ready, mem_wvalid, mem_cmd_valid, rd_data_valid, proto_err}, 0);
    rst = 0; wr_valid = 0;
    @(negedge clk);
    mem_rvalid = 1;
    #1 chk("t6_stray_dv", rd_data_valid, 0);
    @(negedge clk);
    mem_rvalid = 0;
    chk("t6_proto", proto_err, 1);
    @(negedge clk);
    chk("t6_sticky", proto_err, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
